// File: rtl/tutor_pkg.sv
// Shared types for the TutorVHDL counter command driver: opcodes, FSM states,
// default width and MODE argument bit positions.
package tutor_pkg;

  localparam int W_DEFAULT = 4;

  localparam int MODE_SEL = 0;
  localparam int MODE_OE  = 1;
  localparam int MODE_LE  = 2;

  typedef enum logic [2:0] {
    OP_WAIT  = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_UP    = 3'd3,
    OP_DOWN  = 3'd4,
    OP_LATCH = 3'd5,
    OP_MODE  = 3'd6,
    OP_READ  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_SAMPLE = 2'd3
  } state_e;

endpackage

// File: rtl/tutor_shadow_model.sv
// Shadow copy of the counter and its transparent latch, updated from the pin
// values the driver is about to register, plus the expected-value mux.
module tutor_shadow_model
  import tutor_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ce,
  input  logic         load,
  input  logic         dir,
  input  logic         le,
  input  logic [W-1:0] data,
  input  logic         sel,
  output logic [W-1:0] exp_val
);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] latch_q, latch_d;

  function automatic logic [W-1:0] wrap_step(input logic [W-1:0] v, input logic up);
    return up ? v + W'(1) : v - W'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (load) count_d = data;
    else if (ce)   count_d = wrap_step(count_q, dir);
    latch_d = le ? data : latch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      latch_q <= '0;
    end else begin
      count_q <= count_d;
      latch_q <= latch_d;
    end
  end

  assign exp_val = sel ? latch_q : count_q;

endmodule

// File: rtl/tutor_cmd_driver.sv
// Command-driven initiator for the 4-bit counter/latch/mux block: executes one
// command on the counter pins, waits, samples Q and returns one response.
module tutor_cmd_driver
  import tutor_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int LEN_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [W-1:0]     CMD_ARG,
  input  logic [LEN_W-1:0] CMD_LEN,
  output logic             RSP_VALID,
  output logic [W-1:0]     RSP_Q,
  output logic [W-1:0]     RSP_EXP,
  output logic             RSP_MATCH,
  output logic             RSP_HIZ,
  output logic             CNT_CLR,
  output logic             CNT_CE,
  output logic             CNT_LOAD,
  output logic             CNT_DIR,
  output logic             CNT_SEL,
  output logic             CNT_OE,
  output logic             CNT_LE,
  output logic [W-1:0]     CNT_DATA,
  input  logic [W-1:0]     CNT_Q
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [W-1:0]       arg_q, arg_d;
  logic [LEN_W-1:0]   rep_q, rep_d, n_cmd;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               ready_q, ready_d;
  logic               clr_q, clr_d, ce_q, ce_d, load_q, load_d;
  logic               dir_q, dir_d, sel_q, sel_d, oe_q, oe_d;
  logic               le_q, le_d, le_idle_q, le_idle_d;
  logic [W-1:0]       data_q, data_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_match_q, rsp_match_d;
  logic               rsp_hiz_q, rsp_hiz_d;
  logic [W-1:0]       rsp_q_q, rsp_q_d, rsp_exp_q, rsp_exp_d;
  logic [W-1:0]       exp_val;

  always_comb begin
    n_cmd = CMD_LEN;
    case (op_e'(CMD_OP))
      OP_CLEAR:                   if (CMD_LEN == '0) n_cmd = LEN_W'(1);
      OP_LOAD, OP_LATCH, OP_MODE: n_cmd = LEN_W'(1);
      OP_READ:                    n_cmd = '0;
      default:                    ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    rep_d       = rep_q;
    settle_d    = settle_q;
    ready_d     = 1'b0;
    clr_d       = 1'b0;
    ce_d        = 1'b0;
    load_d      = 1'b0;
    dir_d       = dir_q;
    sel_d       = sel_q;
    oe_d        = oe_q;
    le_idle_d   = le_idle_q;
    le_d        = le_idle_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_match_d = rsp_match_q;
    rsp_hiz_d   = rsp_hiz_q;
    rsp_q_d     = rsp_q_q;
    rsp_exp_d   = rsp_exp_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (CMD_VALID && ready_q) begin
          ready_d = 1'b0;
          op_d    = op_e'(CMD_OP);
          arg_d   = CMD_ARG;
          rep_d   = n_cmd;
          if (n_cmd == '0) begin
            state_d  = ST_SETTLE;
            settle_d = SET_W'(SETTLE - 1);
          end else begin
            state_d  = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_CLEAR: clr_d = 1'b1;
          OP_LOAD: begin
            data_d = arg_q;
            load_d = 1'b1;
            ce_d   = 1'b1;
          end
          OP_UP: begin
            ce_d  = 1'b1;
            dir_d = 1'b1;
          end
          OP_DOWN: begin
            ce_d  = 1'b1;
            dir_d = 1'b0;
          end
          OP_LATCH: begin
            data_d = arg_q;
            le_d   = 1'b1;
          end
          OP_MODE: begin
            sel_d     = arg_q[MODE_SEL];
            oe_d      = arg_q[MODE_OE];
            le_idle_d = arg_q[MODE_LE];
            le_d      = arg_q[MODE_LE];
          end
          default: ;
        endcase
        rep_d = rep_q - LEN_W'(1);
        if (rep_q == LEN_W'(1)) begin
          state_d  = ST_SETTLE;
          settle_d = SET_W'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_SAMPLE;
        else                settle_d = settle_q - SET_W'(1);
      end
      ST_SAMPLE: begin
        rsp_valid_d = 1'b1;
        rsp_q_d     = CNT_Q;
        rsp_exp_d   = exp_val;
        rsp_hiz_d   = !oe_q;
        rsp_match_d = oe_q && (CNT_Q == exp_val);
        ready_d     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= ST_IDLE;
      rep_q       <= '0;
      settle_q    <= '0;
      ready_q     <= 1'b0;
      clr_q       <= 1'b1;
      ce_q        <= 1'b0;
      load_q      <= 1'b0;
      dir_q       <= 1'b1;
      sel_q       <= 1'b0;
      oe_q        <= 1'b1;
      le_q        <= 1'b1;
      le_idle_q   <= 1'b1;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_match_q <= 1'b0;
      rsp_hiz_q   <= 1'b0;
      rsp_q_q     <= '0;
      rsp_exp_q   <= '0;
    end else begin
      state_q     <= state_d;
      rep_q       <= rep_d;
      settle_q    <= settle_d;
      ready_q     <= ready_d;
      clr_q       <= clr_d;
      ce_q        <= ce_d;
      load_q      <= load_d;
      dir_q       <= dir_d;
      sel_q       <= sel_d;
      oe_q        <= oe_d;
      le_q        <= le_d;
      le_idle_q   <= le_idle_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_match_q <= rsp_match_d;
      rsp_hiz_q   <= rsp_hiz_d;
      rsp_q_q     <= rsp_q_d;
      rsp_exp_q   <= rsp_exp_d;
    end
  end

  // Latched command fields are only read after acceptance, so they carry no reset.
  always_ff @(posedge CLK) begin
    op_q  <= op_d;
    arg_q <= arg_d;
  end

  tutor_shadow_model #(.W(W)) u_shadow (
    .clk     (CLK),
    .rst     (CLR),
    .clr     (clr_d),
    .ce      (ce_d),
    .load    (load_d),
    .dir     (dir_d),
    .le      (le_d),
    .data    (data_d),
    .sel     (sel_q),
    .exp_val (exp_val)
  );

  assign CMD_READY = ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_Q     = rsp_q_q;
  assign RSP_EXP   = rsp_exp_q;
  assign RSP_MATCH = rsp_match_q;
  assign RSP_HIZ   = rsp_hiz_q;
  assign CNT_CLR   = clr_q;
  assign CNT_CE    = ce_q;
  assign CNT_LOAD  = load_q;
  assign CNT_DIR   = dir_q;
  assign CNT_SEL   = sel_q;
  assign CNT_OE    = oe_q;
  assign CNT_LE    = le_q;
  assign CNT_DATA  = data_q;

endmodule

// File: tb/tb_tutor_cmd_driver.sv
// Bench for tutor_cmd_driver: a behavioural counter answers the pins, and a
// per-command arithmetic model predicts every response.
module tb_tutor_cmd_driver;

  localparam int W = 4, LEN_W = 8, SETTLE = 2;
  localparam int C_WAIT = 0, C_CLEAR = 1, C_LOAD = 2, C_UP = 3;
  localparam int C_DOWN = 4, C_LATCH = 5, C_MODE = 6, C_READ = 7;

  logic             CLK = 1'b0;
  logic             CLR = 1'b1;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic [2:0]       CMD_OP = '0;
  logic [W-1:0]     CMD_ARG = '0;
  logic [LEN_W-1:0] CMD_LEN = '0;
  logic             RSP_VALID, RSP_MATCH, RSP_HIZ;
  logic [W-1:0]     RSP_Q, RSP_EXP;
  logic             CNT_CLR, CNT_CE, CNT_LOAD, CNT_DIR, CNT_SEL, CNT_OE, CNT_LE;
  logic [W-1:0]     CNT_DATA, CNT_Q;

  always #5 CLK = ~CLK;

  tutor_cmd_driver #(.W(W), .LEN_W(LEN_W), .SETTLE(SETTLE)) dut (
    .CLK(CLK), .CLR(CLR),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ARG(CMD_ARG), .CMD_LEN(CMD_LEN),
    .RSP_VALID(RSP_VALID), .RSP_Q(RSP_Q), .RSP_EXP(RSP_EXP),
    .RSP_MATCH(RSP_MATCH), .RSP_HIZ(RSP_HIZ),
    .CNT_CLR(CNT_CLR), .CNT_CE(CNT_CE), .CNT_LOAD(CNT_LOAD), .CNT_DIR(CNT_DIR),
    .CNT_SEL(CNT_SEL), .CNT_OE(CNT_OE), .CNT_LE(CNT_LE),
    .CNT_DATA(CNT_DATA), .CNT_Q(CNT_Q)
  );

  // Behavioural counter block driven by the DUT pins; Q is garbage while OE=0.
  logic [W-1:0] cq = '0, lat = '0, junk = '0;
  always @(posedge CLK) begin
    if (CNT_CLR)       cq <= '0;
    else if (CNT_LOAD) cq <= CNT_DATA;
    else if (CNT_CE)   cq <= CNT_DIR ? cq + 4'd1 : cq - 4'd1;
    if (CNT_LE) lat <= CNT_DATA;
    junk <= 4'($urandom);
  end
  assign CNT_Q = CNT_OE ? (CNT_SEL ? lat : cq) : junk;

  int tests = 0, fails = 0;
  int m_cnt, m_lat, m_sel, m_oe, m_lei, m_data;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_lat = 0; m_sel = 0; m_oe = 1; m_lei = 1; m_data = 0;
  endtask

  task automatic run_cmd(input int op, input int arg, input int len, input bit hold);
    int n, cyc, ce_n, ce_up, ce_dn, clr_n, ld_n, exp_ce, e;
    bit got;
    n = (op == C_WAIT || op == C_UP || op == C_DOWN) ? len :
        (op == C_CLEAR) ? ((len == 0) ? 1 : len) :
        (op == C_READ) ? 0 : 1;
    exp_ce = (op == C_LOAD) ? 1 : (op == C_UP || op == C_DOWN) ? len : 0;
    case (op)
      C_CLEAR: m_cnt = 0;
      C_LOAD:  begin m_cnt = arg; m_data = arg; if (m_lei == 1) m_lat = arg; end
      C_UP:    m_cnt = (m_cnt + len) % 16;
      C_DOWN:  m_cnt = (m_cnt + 16 - (len % 16)) % 16;
      C_LATCH: begin m_data = arg; m_lat = arg; end
      C_MODE:  begin
        m_sel = arg & 1; m_oe = (arg >> 1) & 1; m_lei = (arg >> 2) & 1;
        if (m_lei == 1) m_lat = m_data;
      end
      default: ;
    endcase
    e = (m_sel == 1) ? m_lat : m_cnt;

    cyc = 0;
    while (!CMD_READY && cyc < 400) begin @(negedge CLK); cyc++; end
    check("ready_before_cmd", int'(CMD_READY), 1);
    CMD_VALID = 1'b1; CMD_OP = 3'(op); CMD_ARG = 4'(arg); CMD_LEN = 8'(len);
    @(negedge CLK);
    check("ready_drop_on_accept", int'(CMD_READY), 0);
    if (hold) begin CMD_OP = 3'(C_LOAD); CMD_ARG = ~4'(arg); end
    else CMD_VALID = 1'b0;

    cyc = 0; got = 0; ce_n = 0; ce_up = 0; ce_dn = 0; clr_n = 0; ld_n = 0;
    while (!got && cyc < 600) begin
      @(negedge CLK); cyc++;
      if (RSP_VALID) got = 1;
      else begin
        if (CNT_CE) begin ce_n++; if (CNT_DIR) ce_up++; else ce_dn++; end
        if (CNT_CLR)  clr_n++;
        if (CNT_LOAD) ld_n++;
      end
    end
    if (hold) CMD_VALID = 1'b0;
    check("latency", got ? cyc : -1, 1 + n + SETTLE);
    check("ready_with_rsp", int'(CMD_READY), 1);
    check("ce_cycles", ce_n, exp_ce);
    check("clr_cycles", clr_n, (op == C_CLEAR) ? n : 0);
    check("load_cycles", ld_n, (op == C_LOAD) ? 1 : 0);
    if (op == C_UP)   check("ce_dir_up", ce_up, len);
    if (op == C_DOWN) check("ce_dir_down", ce_dn, len);
    check("rsp_exp", int'(RSP_EXP), e);
    check("rsp_hiz", int'(RSP_HIZ), 1 - m_oe);
    check("rsp_match", int'(RSP_MATCH), m_oe);
    if (m_oe == 1) check("rsp_q", int'(RSP_Q), e);
    @(negedge CLK);
    check("rsp_one_cycle", int'(RSP_VALID), 0);
    check("no_queued_accept", int'(CMD_READY), 1);
  endtask

  initial begin
    int op, arg, len;
    model_reset();
    repeat (3) @(negedge CLK);
    check("reset_cnt_clr", int'(CNT_CLR), 1);
    check("reset_ce", int'(CNT_CE), 0);
    check("reset_dir_oe_le", int'({CNT_DIR, CNT_OE, CNT_LE, CNT_SEL}), 4'b1110);
    check("reset_ready", int'(CMD_READY), 0);
    check("reset_rsp", int'({RSP_VALID, RSP_MATCH, RSP_HIZ}), 0);
    CLR = 1'b0;
    @(negedge CLK);
    check("post_reset_cnt_clr", int'(CNT_CLR), 0);
    check("post_reset_ready", int'(CMD_READY), 1);

    run_cmd(C_READ, 0, 0, 0);
    run_cmd(C_LOAD, 7, 0, 0);
    run_cmd(C_UP, 0, 10, 0);
    run_cmd(C_READ, 0, 0, 0);
    run_cmd(C_DOWN, 0, 3, 0);
    run_cmd(C_READ, 0, 0, 0);
    run_cmd(C_MODE, 3'b001, 0, 0);
    run_cmd(C_LATCH, 5, 0, 0);
    run_cmd(C_LOAD, 9, 0, 0);
    run_cmd(C_READ, 0, 0, 0);
    run_cmd(C_MODE, 3'b000, 0, 0);
    run_cmd(C_READ, 0, 0, 0);
    run_cmd(C_MODE, 3'b110, 0, 0);
    run_cmd(C_READ, 0, 0, 0);
    run_cmd(C_MODE, 3'b011, 0, 0);
    run_cmd(C_READ, 0, 0, 0);
    run_cmd(C_CLEAR, 0, 0, 0);
    run_cmd(C_WAIT, 0, 0, 0);
    run_cmd(C_WAIT, 0, 4, 0);
    run_cmd(C_UP, 0, 4, 1);
    run_cmd(C_UP, 0, 255, 0);
    run_cmd(C_DOWN, 0, 17, 0);

    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 7));
      arg = int'($urandom_range(0, 15));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 12));
      run_cmd(op, arg, len, 0);
    end

    run_cmd(C_MODE, 3'b010, 0, 0);
    CMD_VALID = 1'b1; CMD_OP = 3'(C_UP); CMD_LEN = 8'd50; CMD_ARG = '0;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    repeat (10) @(negedge CLK);
    check("mid_up_ce", int'(CNT_CE), 1);
    CLR = 1'b1;
    @(negedge CLK);
    check("abort_ce", int'(CNT_CE), 0);
    check("abort_cnt_clr", int'(CNT_CLR), 1);
    check("abort_ready", int'(CMD_READY), 0);
    check("abort_data", int'(CNT_DATA), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("abort_no_rsp", int'(RSP_VALID), 0);
    end
    CLR = 1'b0;
    model_reset();
    @(negedge CLK);
    check("abort_release_clr", int'(CNT_CLR), 0);
    check("abort_release_ready", int'(CMD_READY), 1);
    run_cmd(C_READ, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
